// File: rtl/uart_fifo_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_fifo_controller_if                                    |
// | Description : Host-side bus of the UART FIFO controller (FIFO push/pop,  |
// |               occupancy and sticky error flags).                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface uart_fifo_controller_if #(
  parameter int WORD_SIZE = 8,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
);
  logic [WORD_SIZE-1:0]       data_in;
  logic                       write_nic;
  logic                       read_nic;
  logic                       clr_err;
  logic [WORD_SIZE-1:0]       data_out;
  logic                       read_nic_i;
  logic                       tx_full;
  logic [$clog2(TX_DEPTH):0]  tx_count;
  logic [$clog2(RX_DEPTH):0]  rx_count;
  logic [3:0]                 err_flags;

  modport master (
    output data_in, write_nic, read_nic, clr_err,
    input  data_out, read_nic_i, tx_full, tx_count, rx_count, err_flags
  );

  modport slave (
    input  data_in, write_nic, read_nic, clr_err,
    output data_out, read_nic_i, tx_full, tx_count, rx_count, err_flags
  );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_fifo_controller                                       |
// | Description : UART transmitter/receiver with TX and RX FIFOs and sticky  |
// |               error flags. Define UART_PARITY_EN for even parity.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_fifo_controller #(
  parameter int WORD_SIZE    = 8,
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  uart_fifo_controller_if.slave bus,
  input  wire logic             rx,
  output logic                  tx
);
  localparam int c_TXAW = $clog2(TX_DEPTH);
  localparam int c_RXAW = $clog2(RX_DEPTH);
  localparam int c_CW   = $clog2(CLKS_PER_BIT);
  localparam int c_BW   = $clog2(WORD_SIZE);
  localparam logic [c_CW-1:0]   c_CLK_LAST = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0]   c_CLK_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0]   c_CLK_ONE  = c_CW'(1);
  localparam logic [c_BW-1:0]   c_BIT_LAST = c_BW'(WORD_SIZE - 1);
  localparam logic [c_BW-1:0]   c_BIT_ONE  = c_BW'(1);
  localparam logic [c_TXAW:0]   c_TX_FULL  = (c_TXAW + 1)'(TX_DEPTH);
  localparam logic [c_RXAW:0]   c_RX_FULL  = (c_RXAW + 1)'(RX_DEPTH);
  localparam logic [c_TXAW:0]   c_TX_ONE   = (c_TXAW + 1)'(1);
  localparam logic [c_RXAW:0]   c_RX_ONE   = (c_RXAW + 1)'(1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // ---------------- TX FIFO ----------------
  logic [WORD_SIZE-1:0] tx_mem_q [TX_DEPTH];
  logic [c_TXAW-1:0]    tx_wr_q, tx_rd_q;
  logic [c_TXAW:0]      tx_cnt_q;
  logic                 tx_push, tx_pop;

  assign bus.tx_full  = (tx_cnt_q == c_TX_FULL);
  assign bus.tx_count = tx_cnt_q;
  assign tx_push      = bus.write_nic && !bus.tx_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + c_TXAW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + c_TXAW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + c_TX_ONE;
        2'b01:   tx_cnt_q <= tx_cnt_q - c_TX_ONE;
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  state_t               tx_state_q, tx_state_d;
  logic [c_CW-1:0]      tx_clk_q, tx_clk_d;
  logic [c_BW-1:0]      tx_bit_q, tx_bit_d;
  logic [WORD_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
  logic                 tx_tick, tx_load;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  assign tx = tx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= S_IDLE;
      tx_clk_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_clk_q   <= tx_clk_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_clk_d   = tx_clk_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_tick    = (tx_clk_q == c_CLK_LAST);
    tx_clk_d   = tx_tick ? '0 : tx_clk_q + c_CLK_ONE;
    case (tx_state_q)
      S_IDLE: begin
        tx_clk_d = '0;
        tx_load  = (tx_cnt_q != '0);
      end
      S_START: if (tx_tick) begin
        tx_state_d = S_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
      end
      S_DATA: if (tx_tick) begin
        if (tx_bit_q == c_BIT_LAST) begin
`ifdef UART_PARITY_EN
          tx_state_d = S_PARITY;
          tx_d       = tx_par_q;
`else
          tx_state_d = S_STOP;
          tx_d       = 1'b1;
`endif
        end else begin
          tx_bit_d   = tx_bit_q + c_BIT_ONE;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (tx_tick) begin
        tx_state_d = S_STOP;
        tx_d       = 1'b1;
      end
`endif
      S_STOP: if (tx_tick) begin
        tx_state_d = S_IDLE;
        tx_load    = (tx_cnt_q != '0);
      end
      default: tx_state_d = S_IDLE;
    endcase
    // Loading from IDLE or straight out of STOP gives back-to-back frames
    if (tx_load) begin
      tx_state_d = S_START;
      tx_clk_d   = '0;
      tx_shift_d = tx_mem_q[tx_rd_q];
      tx_d       = 1'b0;
`ifdef UART_PARITY_EN
      tx_par_d   = ^tx_mem_q[tx_rd_q];
`endif
    end
    tx_pop = tx_load;
  end

  // ---------------- RX synchroniser and FSM ----------------
  logic                 rx_s1_q, rx_s2_q;
  state_t               rx_state_q, rx_state_d;
  logic [c_CW-1:0]      rx_clk_q, rx_clk_d;
  logic [c_BW-1:0]      rx_bit_q, rx_bit_d;
  logic [WORD_SIZE-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_brk_q, rx_brk_d;
  logic                 rx_tick, rx_push, rx_full, ev_frame, ev_ovf;
`ifdef UART_PARITY_EN
  logic                 rx_perr_q, rx_perr_d, ev_par;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_clk_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_brk_q   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_clk_q   <= rx_clk_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_brk_q   <= rx_brk_d;
`ifdef UART_PARITY_EN
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_brk_d   = rx_brk_q;
    rx_push    = 1'b0;
    ev_frame   = 1'b0;
    ev_ovf     = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
    ev_par     = 1'b0;
`endif
    rx_tick    = (rx_clk_q == c_CLK_LAST);
    rx_clk_d   = rx_tick ? '0 : rx_clk_q + c_CLK_ONE;
    case (rx_state_q)
      S_IDLE: begin
        rx_clk_d = '0;
        rx_bit_d = '0;
        if (!rx_s2_q) rx_state_d = S_START;
      end
      S_START: if (rx_clk_q == c_CLK_HALF) begin
        rx_clk_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_tick) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[WORD_SIZE-1:1]};
        if (rx_bit_q == c_BIT_LAST) begin
          rx_bit_d = '0;
`ifdef UART_PARITY_EN
          rx_state_d = S_PARITY;
`else
          rx_state_d = S_STOP;
`endif
        end else begin
          rx_bit_d = rx_bit_q + c_BIT_ONE;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (rx_tick) begin
        rx_perr_d  = rx_s2_q ^ (^rx_shift_q);
        rx_state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // After a framing error, hold here until the line returns high
        if (rx_brk_q) begin
          rx_clk_d = '0;
          if (rx_s2_q) begin
            rx_brk_d   = 1'b0;
            rx_state_d = S_IDLE;
          end
        end else if (rx_tick) begin
          if (!rx_s2_q) begin
            ev_frame = 1'b1;
            rx_brk_d = 1'b1;
          end else begin
            rx_state_d = S_IDLE;
`ifdef UART_PARITY_EN
            if (rx_perr_q) ev_par = 1'b1;
            else
`endif
            if (rx_full) ev_ovf = 1'b1;
            else         rx_push = 1'b1;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [WORD_SIZE-1:0] rx_mem_q [RX_DEPTH];
  logic [c_RXAW-1:0]    rx_wr_q, rx_rd_q;
  logic [c_RXAW:0]      rx_cnt_q;
  logic [WORD_SIZE-1:0] data_out_q;
  logic                 rx_pop;

  assign rx_full        = (rx_cnt_q == c_RX_FULL);
  assign bus.read_nic_i = (rx_cnt_q != '0);
  assign bus.rx_count   = rx_cnt_q;
  assign bus.data_out   = data_out_q;
  assign rx_pop         = bus.read_nic && bus.read_nic_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      data_out_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + c_RXAW'(1);
      if (rx_pop) begin
        rx_rd_q    <= rx_rd_q + c_RXAW'(1);
        data_out_q <= rx_mem_q[rx_rd_q];
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + c_RX_ONE;
        2'b01:   rx_cnt_q <= rx_cnt_q - c_RX_ONE;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= bus.data_in;
    if (rx_push) rx_mem_q[rx_wr_q] <= rx_shift_q;
  end

  // ---------------- Sticky errors: a same-edge event beats clr_err ----------
  logic [3:0] err_q, err_d;

  always_comb begin
    err_d    = bus.clr_err ? 4'b0000 : err_q;
    err_d[0] = err_d[0] | (bus.write_nic & bus.tx_full);
    err_d[1] = err_d[1] | ev_ovf;
    err_d[2] = err_d[2] | ev_frame;
`ifdef UART_PARITY_EN
    err_d[3] = err_d[3] | ev_par;
`else
    err_d[3] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 4'b0000;
    else      err_q <= err_d;
  end

  assign bus.err_flags = err_q;

endmodule
`default_nettype wire

// File: doc/uart_fifo_controller.md
UART_FIFO_CONTROLLER -- requirements
Module: uart_fifo_controller

Interface
REQ-001 Parameter WORD_SIZE, default 8: data bits per UART frame and FIFO word width; legal range 5..9.
REQ-002 Parameter TX_DEPTH, default 16: TX FIFO entries; power of two, >=2.
REQ-003 Parameter RX_DEPTH, default 16: RX FIFO entries; power of two, >=2.
REQ-004 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; >=4.
REQ-005 Port clk, input, 1: single clock; all state on rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset; asserted when 0.
REQ-007 Port data_in, input, WORD_SIZE: word pushed to TX FIFO.
REQ-008 Port write_nic, input, 1: push data_in into TX FIFO this cycle.
REQ-009 Port read_nic, input, 1: pop RX FIFO head into data_out this cycle.
REQ-010 Port clr_err, input, 1: clears all sticky error flags.
REQ-011 Port rx, input, 1: asynchronous serial input, idle high.
REQ-012 Port tx, output, 1: serial output, idle high.
REQ-013 Port data_out, output, WORD_SIZE: last popped RX word.
REQ-014 Port read_nic_i, output, 1: RX FIFO non-empty.
REQ-015 Port tx_full, output, 1: TX FIFO holds TX_DEPTH words.
REQ-016 Port tx_count, output, $clog2(TX_DEPTH)+1: TX FIFO occupancy.
REQ-017 Port rx_count, output, $clog2(RX_DEPTH)+1: RX FIFO occupancy.
REQ-018 Port err_flags, output, 4: sticky {parity_err, frame_err, rx_overflow, tx_overflow}, bit 3..0.

Function
REQ-019 TX FIFO: write_nic with tx_full=0 stores data_in, increments tx_count next cycle; write_nic with tx_full=1 drops word, sets tx_overflow, no overwrite.
REQ-020 RX FIFO: read_nic with rx_count>0 loads head into data_out on that edge, decrements rx_count; read_nic when empty is ignored, data_out holds.
REQ-021 Pointers wrap modulo depth; simultaneous push and pop on either FIFO leaves count unchanged and both complete.
REQ-022 read_nic_i and tx_full are combinational decodes of registered counts (no extra cycle lag).
REQ-023 TX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START when tx_count>0, popping the head word the same edge.
REQ-024 Frame: start bit 0, WORD_SIZE data bits LSB first, optional parity bit, one stop bit 1; each bit exactly CLKS_PER_BIT cycles; STOP->IDLE after stop bit, back-to-back frames with no idle gap if FIFO non-empty.
REQ-025 rx passes a two-flop synchroniser; RX FSM states IDLE, START, DATA, PARITY, STOP.
REQ-026 RX IDLE->START on synchronised falling edge; start bit resampled at CLKS_PER_BIT/2; if high, return to IDLE (glitch reject), nothing stored.
REQ-027 Data, parity, stop bits sampled at mid-bit, CLKS_PER_BIT after previous sample.
REQ-028 Stop bit sampled 0: set frame_err, discard word, enter IDLE only after rx seen high.
REQ-029 Valid frame with RX FIFO full: discard word, set rx_overflow; existing contents unchanged.
REQ-030 Valid frame written to RX FIFO on the stop-bit sample cycle; simultaneous read_nic on that edge handled per REQ-021.
REQ-031 clr_err clears err_flags next edge; an error event on the same edge wins (flag stays set).

Reset
REQ-032 rst=0 immediately forces: tx=1, data_out=0, counts=0, pointers=0, err_flags=0, both FSMs IDLE, bit counters 0, synchroniser flops=1.
REQ-033 Reset mid-frame aborts the frame; FIFO contents are don't-care; after release TX stays idle until a new write_nic.

Configuration
REQ-034 Macro UART_PARITY_EN defined: PARITY state present in both FSMs, even parity over data bits; RX mismatch sets parity_err and discards word.
REQ-035 UART_PARITY_EN undefined: PARITY state removed (frame = WORD_SIZE+2 bits), err_flags[3] tied 0.

Verification
REQ-036 WORD_SIZE=8, CLKS_PER_BIT=16: write_nic 0xA5 -> tx low 16 cycles, then 1,0,1,0,0,1,0,1 (16 cycles each), [parity 0], stop high.
REQ-037 Loop tx->rx, push 0x00,0x55,0xFF -> rx_count reaches 3, read_nic_i=1, three reads return 0x00,0x55,0xFF, then read_nic_i=0.
REQ-038 Push 17 words with TX_DEPTH=16 while TX busy -> tx_full=1, err_flags[0]=1, 17th word never transmitted; clr_err -> err_flags=0.
REQ-039 Drive 17 frames into rx with no reads -> rx_count=16, err_flags[1]=1, reads return first 16 words in order.
REQ-040 rx low pulse of 4 cycles -> no word stored; frame 0x3C with stop bit 0 -> err_flags[2]=1, rx_count unchanged.
REQ-041 rst=0 for one cycle mid-TX-frame -> tx=1 within same cycle, tx_count=0, err_flags=0; with UART_PARITY_EN, frame with flipped parity bit -> err_flags[3]=1.
